// File: rtl/axis_crc_checker_pkg.sv
// crc_pkg: shared constants, FSM state type and the single-byte CRC step
// used by the AXI-Stream CRC checker.
//   CRC32_*        default CRC-32 (Ethernet FCS) parameters
//   crc_state_e    frame tracking state
//   crc_byte_update one byte of CRC update for a CRC of up to 32 bits
package crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } crc_state_e;

    // Advance a width-bit CRC register by one byte. The polynomial is given in
    // normal form; for reflect=1 it is mirrored and the register shifts right,
    // which matches LSB-first transmission (register held in reflected order).
    function automatic logic [31:0] crc_byte_update(
        input logic [31:0] crc,
        input logic [7:0]  data,
        input logic [31:0] poly,
        input logic        reflect,
        input int          width = 32
    );
        logic [31:0] c;
        logic [31:0] p;
        logic [31:0] t;
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        c = crc & mask;
        p = '0;
        if (reflect) begin
            // Mirror the low width bits of poly: poly bit 0 lands in bit width-1.
            for (int i = 0; i < 32; i++) begin
                if (i < width) begin
                    t = poly >> i;
                    p = {p[30:0], t[0]};
                end
            end
            c = c ^ {24'd0, data};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
            end
        end else begin
            c = c ^ ({24'd0, data} << (width - 8));
            for (int b = 0; b < 8; b++) begin
                t = c >> (width - 1);
                c = t[0] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
            end
        end
        return c & mask;
    endfunction

endpackage

// File: rtl/axis_crc_checker_if.sv
// AXI-Stream bundle used on both sides of the CRC checker.
//   master modport: drives tdata/tkeep/tvalid/tlast/tuser, receives tready
//   slave modport:  receives tdata/tkeep/tvalid/tlast, drives tready
interface axis_crc_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast,
                    output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                    output tready);
endinterface

// File: rtl/axis_crc_checker_byte_engine.sv
// crc_byte_engine: combinational CRC update over one stream beat.
//   crc_in   register value before the beat
//   data     beat data, byte 0 in [7:0] and first on the wire
//   keep     byte enables; a cleared byte leaves the CRC untouched
//   crc_out  register value after all kept bytes, processed 0..N-1
module crc_byte_engine
    import crc_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter bit          REFLECT    = 1'b1
) (
    input  logic [CRC_WIDTH-1:0]    crc_in,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] keep,
    output logic [CRC_WIDTH-1:0]    crc_out
);
    localparam int NB = DATA_WIDTH / 8;

    logic [CRC_WIDTH-1:0] chain [NB+1];

    assign chain[0] = crc_in;

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign chain[i+1] = keep[i]
            ? CRC_WIDTH'(crc_byte_update(32'(chain[i]), data[8*i +: 8], POLY, REFLECT, CRC_WIDTH))
            : chain[i];
    end

    assign crc_out = chain[NB];
endmodule

// File: rtl/axis_crc_checker.sv
// axis_crc_checker: inline receive-path CRC checker with a one-deep register
// stage. Every beat passes through unchanged; on the last beat of an enabled
// frame tuser flags a CRC error or a runt and the statistics counters update.
//   axis_aclk, axis_areset  clock, asynchronous active-high reset
//   enable                  checking enable, latched on the first beat of a frame
//   clear_counters          synchronous clear, wins over an increment
//   s_axis / m_axis         input and registered output stream
//   crc_flag                one-cycle pulse with an errored frame's last beat
//   *_count_out             saturating frame / error / runt counters
module axis_crc_checker
    import crc_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          CRC_WIDTH   = 32,
    parameter logic [31:0] POLY        = CRC32_POLY,
    parameter logic [31:0] INIT        = CRC32_INIT,
    parameter bit          REFLECT     = 1'b1,
    parameter logic [31:0] RESIDUE     = CRC32_RESIDUE,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    input  logic                   enable,
    input  logic                   clear_counters,
    axis_crc_checker_if.slave      s_axis,
    axis_crc_checker_if.master     m_axis,
    output logic                   crc_flag,
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic [COUNT_WIDTH-1:0] error_count_out,
    output logic [COUNT_WIDTH-1:0] runt_count_out
);
    localparam int          KEEP_W    = DATA_WIDTH / 8;
    localparam logic [7:0]  MIN_BYTES = 8'(CRC_WIDTH / 8 + 1);
    localparam logic [CRC_WIDTH-1:0] INIT_C    = INIT[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] RESIDUE_C = RESIDUE[CRC_WIDTH-1:0];

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only "fewer than MIN_BYTES" matters, so the byte count stops there.
    function automatic logic [7:0] sat_bytes(input logic [7:0] v);
        return (v >= MIN_BYTES) ? MIN_BYTES : v;
    endfunction

    crc_state_e state_q, state_d;

    logic                  accept;
    logic                  first;
    logic                  en_q, en_eff;
    logic [CRC_WIDTH-1:0]  crc_q, crc_start, crc_next;
    logic [7:0]            cnt_q, beat_bytes, cnt_sat;
    logic                  runt, bad, err;

    logic [DATA_WIDTH-1:0] tdata_p1;
    logic [KEEP_W-1:0]     tkeep_p1;
    logic                  tlast_p1, tuser_p1, vld_p1, flag_p1;

    assign accept    = s_axis.tvalid && s_axis.tready;
    assign first     = (state_q == IDLE);
    assign crc_start = first ? INIT_C : crc_q;
    assign en_eff    = first ? enable : en_q;

    crc_byte_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (POLY),
        .REFLECT    (REFLECT)
    ) u_engine (
        .crc_in  (crc_start),
        .data    (s_axis.tdata),
        .keep    (s_axis.tkeep),
        .crc_out (crc_next)
    );

    assign beat_bytes = 8'($countones(s_axis.tkeep));
    assign cnt_sat    = sat_bytes((first ? 8'd0 : cnt_q) + beat_bytes);
    assign runt       = (cnt_sat < MIN_BYTES);
    assign bad        = (crc_next != RESIDUE_C);
    assign err        = en_eff && (runt || bad);

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = s_axis.tlast ? IDLE : BODY;
    end

    // ---- stage p0: per-frame CRC context, carried across beats ----
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            crc_q <= INIT_C;
            cnt_q <= 8'd0;
            en_q  <= 1'b0;
        end else if (accept) begin
            if (s_axis.tlast) begin
                crc_q <= INIT_C;
                cnt_q <= 8'd0;
            end else begin
                crc_q <= crc_next;
                cnt_q <= cnt_sat;
            end
            en_q <= en_eff;
        end
    end

    // ---- stage p1: output register, verdict and statistics ----
    assign s_axis.tready = !vld_p1 || m_axis.tready;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= '0;
            tkeep_p1 <= '0;
            tlast_p1 <= 1'b0;
            tuser_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            tdata_p1 <= s_axis.tdata;
            tkeep_p1 <= s_axis.tkeep;
            tlast_p1 <= s_axis.tlast;
            tuser_p1 <= s_axis.tlast && err;
        end else if (m_axis.tready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            flag_p1         <= 1'b0;
            frame_count_out <= '0;
            error_count_out <= '0;
            runt_count_out  <= '0;
        end else begin
            flag_p1 <= accept && s_axis.tlast && err;
            if (clear_counters) begin
                frame_count_out <= '0;
                error_count_out <= '0;
                runt_count_out  <= '0;
            end else if (accept && s_axis.tlast && en_eff) begin
                frame_count_out <= sat_inc(frame_count_out);
                if (err)  error_count_out <= sat_inc(error_count_out);
                if (runt) runt_count_out  <= sat_inc(runt_count_out);
            end
        end
    end

    assign m_axis.tvalid = vld_p1;
    assign m_axis.tdata  = tdata_p1;
    assign m_axis.tkeep  = tkeep_p1;
    assign m_axis.tlast  = tlast_p1;
    assign m_axis.tuser  = tuser_p1;
    assign crc_flag      = flag_p1;
endmodule

// File: tb/tb_axis_crc_checker.sv
module tb_axis_crc_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, clear_counters;
    logic crc_flag, crc_flag4;
    logic [31:0] frame_cnt, err_cnt, runt_cnt;
    logic [3:0]  frame4, err4, runt4;

    axis_crc_checker_if #(.DATA_WIDTH(32)) s_if ();
    axis_crc_checker_if #(.DATA_WIDTH(32)) m_if ();
    axis_crc_checker_if #(.DATA_WIDTH(32)) s4_if ();
    axis_crc_checker_if #(.DATA_WIDTH(32)) m4_if ();

    // Second instance with 4-bit counters sees the identical stream.
    assign s_if.tuser   = 1'b0;
    assign s4_if.tuser  = 1'b0;
    assign s4_if.tdata  = s_if.tdata;
    assign s4_if.tkeep  = s_if.tkeep;
    assign s4_if.tvalid = s_if.tvalid;
    assign s4_if.tlast  = s_if.tlast;
    assign m4_if.tready = m_if.tready;

    axis_crc_checker dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .enable          (enable),
        .clear_counters  (clear_counters),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .crc_flag        (crc_flag),
        .frame_count_out (frame_cnt),
        .error_count_out (err_cnt),
        .runt_count_out  (runt_cnt)
    );

    axis_crc_checker #(.COUNT_WIDTH(4)) dut4 (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .enable          (enable),
        .clear_counters  (clear_counters),
        .s_axis          (s4_if),
        .m_axis          (m4_if),
        .crc_flag        (crc_flag4),
        .frame_count_out (frame4),
        .error_count_out (err4),
        .runt_count_out  (runt4)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    flag_seen = 0;
    bit    mon_en = 1'b1;
    bit    rnd_ready = 1'b0;

    logic [7:0] good_f[$];
    logic [7:0] bad_f[$];
    logic [7:0] runt_f[$];
    logic [7:0] a_f[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Downstream ready changes just after the active edge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, where a transfer is decided.
    initial begin
        beat_t       e;
        logic        stalled;
        logic [31:0] hd;
        logic [5:0]  hc;
        stalled = 1'b0;
        hd = '0;
        hc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (crc_flag) flag_seen++;
                if (stalled && m_if.tvalid) begin
                    check("hold_data", m_if.tdata, hd);
                    check("hold_ctl", {26'd0, m_if.tkeep, m_if.tlast, m_if.tuser}, {26'd0, hc});
                end
                if (mon_en && m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %h expected no beat", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_if.tdata, e.data);
                        check("out_keep_last_user", {26'd0, m_if.tkeep, m_if.tlast, m_if.tuser},
                              {26'd0, e.keep, e.last, e.user});
                    end
                end
                stalled = m_if.tvalid && !m_if.tready;
                hd = m_if.tdata;
                hc = {m_if.tkeep, m_if.tlast, m_if.tuser};
            end
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic en, input logic clr, input logic u, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        s_if.tdata     = d;
        s_if.tkeep     = k;
        s_if.tlast     = l;
        s_if.tvalid    = 1'b1;
        enable         = en;
        clear_counters = clr;
        while (!s_if.tready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) fail_now("tready_timeout");
        if (push) begin
            beat_t b;
            b.data = d;
            b.keep = k;
            b.last = l;
            b.user = u;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        s_if.tvalid    = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input logic en0, input logic en1,
                              input logic user, input bit clr_last, input bit empty_tail);
        int n;
        int nb;
        n  = fb.size();
        nb = (n + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (bi * 4 + j < n) begin
                    d = d | (32'(fb[bi*4+j]) << (8 * j));
                    k = k | (4'd1 << j);
                end
            end
            l = (bi == nb - 1) && !empty_tail;
            drive_beat(d, k, l, (bi == 0) ? en0 : en1, l && clr_last, l ? user : 1'b0, 1'b1);
        end
        if (empty_tail) drive_beat(32'd0, 4'd0, 1'b1, en1, clr_last, user, 1'b1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) fail_now("drain");
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag, input int f, input int e, input int r, input int fl);
        check({tag, "_frame"}, frame_cnt, 32'(f));
        check({tag, "_error"}, err_cnt, 32'(e));
        check({tag, "_runt"},  runt_cnt, 32'(r));
        check({tag, "_flags"}, 32'(flag_seen), 32'(fl));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // "123456789" + CRC-32 FCS (0xCBF43926, LSB first)
        good_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        bad_f  = '{8'h31, 8'h32, 8'h33, 8'h35, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        runt_f = '{8'h31, 8'h32, 8'h33};
        // "a" + FCS (0xE8B7BE43): exactly the minimum 5 bytes
        a_f    = '{8'h61, 8'h43, 8'hBE, 8'hB7, 8'hE8};

        rst = 1'b1;
        enable = 1'b1;
        clear_counters = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_tdata", m_if.tdata, 32'd0);
        check("rst_ctl", {26'd0, m_if.tkeep, m_if.tlast, m_if.tuser}, 32'd0);
        check("rst_flag", {31'd0, crc_flag}, 32'd0);
        check("rst_counts", frame_cnt | err_cnt | runt_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tready", {31'd0, s_if.tready}, 32'd1);

        flag_seen = 0;
        send_frame(good_f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("good", 1, 0, 0, 0);

        send_frame(bad_f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("bad", 2, 1, 0, 1);

        send_frame(runt_f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("runt", 3, 2, 1, 2);

        flag_seen = 0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            case (i % 3)
                0:       send_frame(good_f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                1:       send_frame(a_f,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                default: send_frame(a_f,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            endcase
        end
        rnd_ready = 1'b0;
        drain();
        check_counts("stream", 103, 2, 1, 0);

        send_frame(bad_f, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("disabled", 103, 2, 1, 0);

        for (int i = 0; i < 17; i++) send_frame(runt_f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("sat_wide", 120, 19, 18, 17);
        check("sat4_frame", {28'd0, frame4}, 32'hF);
        check("sat4_error", {28'd0, err4}, 32'hF);
        check("sat4_runt",  {28'd0, runt4}, 32'hF);

        flag_seen = 0;
        send_frame(good_f, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        check_counts("clear", 0, 0, 0, 0);
        check("clear4", {28'd0, frame4 | err4 | runt4}, 32'd0);

        send_frame(bad_f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("prereset", 1, 1, 0, 1);

        mon_en = 1'b0;
        drive_beat(32'h34333231, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_beat(32'h38373635, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_if.tdata  = 32'hF4392639;
        s_if.tkeep  = 4'hF;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("midrst_tdata", m_if.tdata, 32'd0);
        check("midrst_ctl", {26'd0, m_if.tkeep, m_if.tlast, m_if.tuser}, 32'd0);
        check("midrst_counts", frame_cnt | err_cnt | runt_cnt, 32'd0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        flag_seen = 0;
        send_frame(good_f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("postreset", 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_crc_checker.md
# axis_crc_checker

Parametrised multi-width AXI-Stream CRC checker for the receive path, generalising `crc_wrapper`. It sits inline between an upstream AXI-Stream source and downstream logic and passes every beat through a one-deep register stage. On each frame it computes a byte-granular CRC over payload plus trailing FCS. It flags errored frames on `m_axis_tuser` and keeps saturating frame, error and runt counters.

## Interface
- `DATA_WIDTH`, 32: stream width in bits; multiple of 8, 8..512.
- `CRC_WIDTH`, 32: CRC register width; multiple of 8, 8..32.
- `POLY`, 32'h04C11DB7: generator polynomial, normal (non-reflected) form.
- `INIT`, 32'hFFFFFFFF: register value at frame start.
- `REFLECT`, 1: 1 = LSB-first bit processing within each byte; 0 = MSB-first.
- `RESIDUE`, 32'hDEBB20E3: expected raw register after the last FCS byte, before any output XOR.
- `COUNT_WIDTH`, 32: width of the statistics counters.
- `axis_aclk`, in, 1: clock.
- `axis_areset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: checking enable; sampled on the first beat of each frame.
- `clear_counters`, in, 1: synchronous clear of all counters.
- `s_axis_tdata`, in, DATA_WIDTH: input data; byte 0 is `[7:0]` and is first on the wire.
- `s_axis_tkeep`, in, DATA_WIDTH/8: byte enables; all ones except on the last beat.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast`: input handshake signals.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tvalid` / `m_axis_tready` / `m_axis_tlast`: output stream, registered copy of the input.
- `m_axis_tuser`, out, 1: on the last beat, 1 = CRC error or runt. 0 on all other beats.
- `crc_flag`, out, 1: one-cycle pulse when an errored frame's last beat is accepted at the input.
- `frame_count_out`, `error_count_out`, `runt_count_out`, out, COUNT_WIDTH each: saturating statistics counters.

## Operation
- FSM states:
  - IDLE → BODY on an accepted non-last beat.
  - BODY → IDLE on an accepted last beat.
  - A single-beat frame (tlast on the first beat) stays in IDLE.
- Beat acceptance: a beat is accepted when `s_axis_tvalid && s_axis_tready`.
- CRC update:
  - Per accepted beat, the CRC is updated byte by byte in order 0..N-1.
  - Bytes with `tkeep`=0 are skipped.
  - The update is fully unrolled and combinational within one cycle.
  - The first beat starts from `INIT`, not from the stored register.
- Byte counter:
  - Counts kept bytes in the frame.
  - Saturates at CRC_WIDTH/8+1; no wrap.
- Frame verdict, computed on the last beat:
  - Runt: total bytes < CRC_WIDTH/8+1.
  - Bad CRC: raw register ≠ `RESIDUE`.
  - Error = enabled && (runt || bad CRC).
- Enable handling:
  - `enable` is latched on the first beat; mid-frame changes are ignored.
  - Disabled frame: data still passes through, `tuser`=0, `crc_flag`=0, all counters unchanged.
- Counters, updated on the last-beat accept of an enabled frame:
  - `frame_count_out` +1.
  - `error_count_out` +1 if error.
  - `runt_count_out` +1 if runt (a runt also counts as an error).
  - Each counter saturates at all-ones.
  - `clear_counters` has priority over a simultaneous increment; counters read 0 the next cycle.
- `tkeep` rules:
  - `tkeep` is assumed contiguous from bit 0.
  - A beat with `tkeep` all zero is accepted and ignored for the CRC; its tlast still ends the frame.

## Timing
- Latency: one cycle, input accept → `m_axis_tvalid`.
- Ready rule: `s_axis_tready = !m_axis_tvalid || m_axis_tready`. This gives full throughput with no bubbles.
- Output hold: `m_axis_*` hold stable while `m_axis_tvalid && !m_axis_tready`.
- `crc_flag` and counter updates occur the cycle after the last-beat accept, aligned with `m_axis_tlast`/`tuser` appearing on the output.
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`/`tkeep`/`tlast`/`tuser`=0, `crc_flag`=0, all counters 0, FSM in IDLE, CRC register = `INIT`.
- Reset mid-frame: the partial frame is discarded and not counted. The first beat after reset starts a new frame.

## Structure
- Package `crc_pkg`:
  - Default CRC-32 constants (`POLY`, `INIT`, `RESIDUE`).
  - FSM state enum `crc_state_e` {IDLE, BODY}.
  - Function `crc_byte_update(crc, byte, poly, reflect)`.
- Sub-module `crc_byte_engine`: combinational DATA_WIDTH/8-byte unrolled update with keep masking. It is instanced once.

## Test plan
- Single 8-byte beat, ASCII "1234" + FCS 26 39 F4 CB wrong for payload? No: use 13-byte frame "123456789" + 26 39 F4 CB over 4 beats, last `tkeep`=4'b0001 → `tuser`=1'b0 on last beat, frame_count=1, error_count=0.
- Same frame with byte 3 flipped to 0x35 → `tuser`=1, `crc_flag` pulses once, error_count=1.
- 3-byte frame (single beat, `tkeep`=4'b0111) → runt_count=1, error_count=1, tuser=1.
- Random `m_axis_tready` (50%) with 100 back-to-back good frames → data byte-exact at output, frame_count=100, no lost or duplicated beats.
- `enable`=0 on first beat of a bad frame, raised mid-frame → tuser=0, counters unchanged. Preload `error_count_out`=all-ones via forced errors at COUNT_WIDTH=4 → stays 4'hF. Then `clear_counters` coincident with a last beat → reads 0.
- Assert `axis_areset` during beat 2 of a frame → outputs at reset values. The next good frame is counted as frame_count=1 with no error.
